tanh_req_scheduler: RTL and testbench
=====================================

Name: tanh_req_scheduler

Overview:
Shares one pipelined CORDIC tanh core (hyperbolic rotation followed by CORDIC division, 16-bit result) among N requesters. It performs round-robin issue of at most one angle per cycle into the core. Each issue is tagged with its requester ID, and the tags travel in a shift register matched to the core latency. Each result is returned to its originating requester with a per-requester outstanding limit. The block sits between the ICA update engines and the single tanh core instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
WORD_SZ, 32, angle width fed to core
OUT_SZ, 16, core result width
CORE_LAT, 30, core register depth from core_angle sampled to core_result updated (15 rotation + 14 division + 1 output)
MAX_OUT, 4, max in-flight requests per requester (1..CORE_LAT+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  request present, one bit per requester
req_angle  in  N_REQ*WORD_SZ  packed angles; requester i at [i*WORD_SZ +: WORD_SZ]
req_ready  out  N_REQ  one-hot (or zero); transfer when req_valid[i]&req_ready[i]
hold  in  1  block new grants; in-flight work drains
core_angle  out  WORD_SZ  registered angle to tanh core
core_result  in  OUT_SZ  tanh core output
rsp_valid  out  N_REQ  one-hot pulse, result for requester i
rsp_data  out  OUT_SZ  result value
rsp_id  out  $clog2(N_REQ)  index of rsp_valid bit set
busy  out  1  any tag in flight or any rsp pending

Behaviour:
- Reset (async assert; release is synchronised by the system): core_angle=0, rsp_valid=0, rsp_data=0, rsp_id=0, all tags invalid, all outstanding counters 0, rr pointer 0, busy=0.
- Eligibility: eligible[i] = req_valid[i] & (cnt[i] < MAX_OUT) & ~hold.
- Grant is combinational from eligible and the rr pointer: the first eligible index at or after ptr, wrapping. req_ready is one-hot at that index, else 0. req_ready never depends on core_result.
- On a transfer of requester g at edge k:
  - core_angle <= req_angle[g];
  - tag[0] <= {valid=1, id=g};
  - ptr <= (g+1) mod N_REQ.
- With no transfer: tag[0].valid <= 0; core_angle and ptr hold.
- Tag pipe depth CORE_LAT+1. It shifts every cycle with no stall, because the core cannot stall.
- Result: the transfer at edge k has its response registered at edge k+CORE_LAT+1:
  - rsp_valid[id]=1 for exactly one cycle;
  - rsp_data=core_result;
  - rsp_id=id.
- Invalid tags produce rsp_valid=0. rsp_data/rsp_id then hold their last values.
- No response backpressure: a requester must accept rsp_valid in the cycle it is asserted.
- cnt[i]: +1 on transfer from i, -1 on rsp for i, unchanged if both occur in the same cycle. It never exceeds MAX_OUT or goes below 0.
- Back-to-back: one requester alone may issue every cycle until cnt reaches MAX_OUT. It resumes in the cycle after a response lowers cnt.
- Throughput: full rate, one issue per cycle when eligible requesters exist.
- hold: takes effect combinationally in the same cycle. Tags and responses continue to drain.
- busy = OR of tag valids OR any rsp_valid.
- Reset mid-operation: all tags are invalidated, so in-flight core results are discarded (the core itself has no reset). No rsp_valid is issued for them, and counters return to 0.
- ptr advances only on a transfer, so a requester with a cleared req_valid cannot be skipped unfairly.

Decomposition:
- Package tanh_pkg:
  - constants CORDIC_WORD_SZ=32, TANH_OUT_SZ=16, TANH_CORE_LAT=30;
  - typedef tanh_tag_t {logic valid; logic [ID_W-1:0] id;}.
- Sub-module rr_arbiter: combinational grant from eligible and ptr, plus registered ptr update. Parameter N.
- Tag pipe, counters and response register stay in the top module.

Test Plan:
- Bench core stub: a CORE_LAT delay line mapping core_angle[15:0] to core_result.
- Single request: requester 2 issues angle 0x0000_1234 at edge 10 -> rsp_valid=4'b0100, rsp_data=0x1234, rsp_id=2 after edge 41; busy deasserts after edge 42.
- All four req_valid held high with distinct angles: grants cycle 0,1,2,3,0,... each cycle. Responses return in the same order, one per cycle, after the 31-cycle offset.
- Only requester 1 valid, MAX_OUT=4: 4 transfers on consecutive edges, then req_ready=0 until the first rsp. The 5th transfer occurs on the edge after the first rsp edge; cnt never exceeds 4.
- hold=1 asserted with 3 in flight: req_ready=0 immediately, exactly 3 responses still arrive, then busy=0. Deasserting hold resumes grants at the saved ptr.
- rst pulsed at edge 20 with 5 requests in flight: no rsp_valid ever occurs for them, all counters read 0, and the next request returns correctly after 31 cycles.
- Simultaneous issue and response for the same requester with cnt=MAX_OUT-1: cnt stays MAX_OUT-1 and the requester remains eligible.

Source files
------------

// File: rtl/tanh_pkg.sv
// tanh_pkg: shared constants and the tag type for the tanh request scheduler.
//   CORDIC_WORD_SZ : angle width presented to the CORDIC tanh core
//   TANH_OUT_SZ    : tanh result width
//   TANH_CORE_LAT  : core depth, core_angle sample to core_result update
//   tanh_tag_t     : requester tag that rides alongside the core pipeline
package tanh_pkg;
    localparam int CORDIC_WORD_SZ = 32;
    localparam int TANH_OUT_SZ    = 16;
    localparam int TANH_CORE_LAT  = 30;
    localparam int MAX_REQ        = 8;
    // Sized for the largest supported requester count; the top uses the low bits.
    localparam int TAG_ID_W       = $clog2(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tanh_tag_t;
endpackage

// File: rtl/tanh_req_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant over N eligible bits.
//   clk, rst  : clock, async active-high reset (ptr -> 0)
//   eligible  : per-requester eligibility
//   grant     : one-hot grant (or zero), first eligible index at or after ptr
//   grant_id  : index of the granted requester
//   grant_any : a grant was made this cycle
// The pointer moves only on a grant, so an idle requester never loses its turn.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         eligible,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_any
);
    localparam int W = $clog2(N);

    logic [W-1:0] ptr;
    logic [W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int o = 0; o < N; o++) begin
            idx = W'((int'(ptr) + o) % N);
            if (!grant_any && eligible[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (grant_any)
            ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/tanh_req_scheduler.sv
// tanh_req_scheduler: shares one pipelined CORDIC tanh core among N_REQ requesters.
//   clk, rst    : clock, async active-high reset
//   req_valid   : per-requester request present
//   req_angle   : packed angles, requester i at [i*WORD_SZ +: WORD_SZ]
//   req_ready   : one-hot grant (or zero)
//   hold        : block new grants; in-flight work drains
//   core_angle  : registered angle to the core
//   core_result : core output
//   rsp_valid   : one-hot response pulse
//   rsp_data    : response value
//   rsp_id      : index of the rsp_valid bit set
//   busy        : any tag in flight or a response pending
// One issue per cycle; a tag pipe of depth CORE_LAT+1 tracks the owner of each
// core slot. The core cannot stall, so the tag pipe never stalls either.
module tanh_req_scheduler
    import tanh_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WORD_SZ  = CORDIC_WORD_SZ,
    parameter int OUT_SZ   = TANH_OUT_SZ,
    parameter int CORE_LAT = TANH_CORE_LAT,
    parameter int MAX_OUT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WORD_SZ-1:0] req_angle,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     hold,
    output logic [WORD_SZ-1:0]       core_angle,
    input  logic [OUT_SZ-1:0]        core_result,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [OUT_SZ-1:0]        rsp_data,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     busy
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [N_REQ-1:0]            eligible;
    logic [N_REQ-1:0]            grant;
    logic [ID_W-1:0]             gnt_id;
    logic                        gnt_any;
    logic [N_REQ-1:0][CNT_W-1:0] cnt;
    logic [N_REQ-1:0]            at_max;
    logic [N_REQ-1:0]            rsp_hit;
    tanh_tag_t                   tag_pipe [CORE_LAT+1];
    tanh_tag_t                   out_tag;
    logic                        tags_busy;

    // Eligibility: hold and the outstanding limit gate grants combinationally.
    always_comb begin
        at_max = '0;
        for (int i = 0; i < N_REQ; i++)
            at_max[i] = (int'(cnt[i]) >= MAX_OUT);
    end

    assign eligible  = req_valid & ~at_max & {N_REQ{~hold}};
    assign req_ready = grant;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .eligible  (eligible),
        .grant     (grant),
        .grant_id  (gnt_id),
        .grant_any (gnt_any)
    );

    // Issue register and tag pipe. tag_pipe[CORE_LAT] lines up with the edge
    // at which core_result carries the result for that slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_angle <= '0;
            for (int j = 0; j <= CORE_LAT; j++)
                tag_pipe[j] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: gnt_any, id: TAG_ID_W'(gnt_id)};
            for (int j = 1; j <= CORE_LAT; j++)
                tag_pipe[j] <= tag_pipe[j-1];
            if (gnt_any)
                core_angle <= req_angle[int'(gnt_id)*WORD_SZ +: WORD_SZ];
        end
    end

    assign out_tag = tag_pipe[CORE_LAT];

    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < N_REQ; i++)
            rsp_hit[i] = out_tag.valid && (out_tag.id == TAG_ID_W'(i));
    end

    // Response register; data/id keep their last value between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= rsp_hit;
            if (out_tag.valid) begin
                rsp_data <= core_result;
                rsp_id   <= ID_W'(out_tag.id);
            end
        end
    end

    // Outstanding counters; issue and retire in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && !rsp_hit[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (rsp_hit[i] && !grant[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int j = 0; j <= CORE_LAT; j++)
            tags_busy |= tag_pipe[j].valid;
    end

    assign busy = tags_busy | (|rsp_valid);
endmodule

// File: tb/tb_tanh_req_scheduler.sv
// Bench for tanh_req_scheduler: directed stimulus, a core stub delay line and
// a scoreboard queue popped by a negedge monitor.
module tb_tanh_req_scheduler;
    localparam int N   = 4;
    localparam int WS  = 32;
    localparam int OS  = 16;
    localparam int LAT = 30;
    localparam int MO  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*WS-1:0] req_angle = '0;
    logic [N-1:0]    req_ready;
    logic            hold = 1'b0;
    logic [WS-1:0]   core_angle;
    logic [OS-1:0]   core_result;
    logic [N-1:0]    rsp_valid;
    logic [OS-1:0]   rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;

    tanh_req_scheduler #(.N_REQ(N), .WORD_SZ(WS), .OUT_SZ(OS), .CORE_LAT(LAT), .MAX_OUT(MO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_angle   (req_angle),
        .req_ready   (req_ready),
        .hold        (hold),
        .core_angle  (core_angle),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Core stub: result updated LAT edges after core_angle is registered.
    logic [OS-1:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= core_angle[OS-1:0];
        for (int j = 1; j < LAT; j++) dl[j] <= dl[j-1];
    end
    assign core_result = dl[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          at;
    } exp_t;
    exp_t q[$];
    exp_t e;

    logic       chk_rdy = 1'b0, chk_busy = 1'b0, chk_rst = 1'b0, chk_empty = 1'b0;
    logic [3:0] exp_rdy = '0;
    logic       exp_busy = 1'b0;
    int         checks = 0, errors = 0;
    int         seq = 0;

    always @(negedge clk) begin
        if (chk_rdy) begin
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL req_ready cyc=%0d got %b want %b", cyc, req_ready, exp_rdy);
            end
        end
        if (chk_busy) begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
            end
        end
        if (chk_rst) begin
            checks++;
            if (core_angle !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_id !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got angle=%h rv=%b rd=%h rid=%0d busy=%b want all zero",
                         cyc, core_angle, rsp_valid, rsp_data, rsp_id, busy);
            end
        end
        if (chk_empty) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drained cyc=%0d got %0d responses missing want 0", cyc, q.size());
            end
        end
        if (!rst && rsp_valid !== '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp cyc=%0d got rv=%b rd=%h want none", cyc, rsp_valid, rsp_data);
            end else begin
                e = q.pop_front();
                if (rsp_valid !== (4'b0001 << e.id) || rsp_data !== e.data ||
                    rsp_id !== 2'(e.id) || cyc != e.at) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d got rv=%b rd=%h rid=%0d want rv=%b rd=%h rid=%0d at=%0d",
                             cyc, rsp_valid, rsp_data, rsp_id, 4'b0001 << e.id, e.data, e.id, e.at);
                end
            end
        end
    end

    function automatic int oh2id(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One cycle of stimulus. exp is the grant expected this cycle; when psh is
    // set the matching response is queued for the edge LAT+1 after the transfer.
    task automatic cycle(input logic [3:0] v, input logic [3:0] exp, input logic h,
                         input logic psh, input logic cb, input logic bv, input logic ce);
        seq++;
        for (int i = 0; i < N; i++) req_angle[i*WS +: WS] = {16'hBEEF, 4'(i), 12'(seq)};
        req_valid = v;
        hold      = h;
        exp_rdy   = exp;
        chk_rdy   = 1'b1;
        chk_busy  = cb;
        exp_busy  = bv;
        chk_empty = ce;
        chk_rst   = 1'b0;
        if (psh && exp != 4'b0000)
            q.push_back('{id: oh2id(exp), data: {4'(oh2id(exp)), 12'(seq)}, at: cyc + LAT + 2});
        @(posedge clk); #1;
    endtask

    task automatic drain(input int n, input logic all_idle);
        for (int j = 0; j < n; j++)
            cycle(4'b0000, 4'b0000, 1'b0, 1'b0, all_idle || (j == n - 1), 1'b0, j == n - 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1; req_valid = '0; hold = 1'b0;
        chk_rdy = 1'b0; chk_busy = 1'b0; chk_empty = 1'b0; chk_rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; chk_rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        pulse_rst();

        // Single request from requester 2 (ptr 0 -> first eligible is 2).
        cycle(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= 32; j++)
            cycle(4'b0000, 4'b0000, 1'b0, 1'b0, j >= 31, j == 31, j == 32);

        // All requesters valid after a reset: grants 0,1,2,3,0,1,2,3.
        pulse_rst();
        for (int c = 0; c < 8; c++)
            cycle(4'b1111, 4'b0001 << (c % 4), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(40, 1'b0);

        // Requester 1 alone: 4 issues, stall, resume on the edge after the
        // first response, and stay eligible while issue and retire coincide.
        for (int c = 0; c < 40; c++)
            cycle(4'b0010, ((c < 4) || (c >= 32 && c < 36)) ? 4'b0010 : 4'b0000,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(40, 1'b0);

        // Hold with 3 in flight (ptr 2 -> grants 2,3,0), then resume at ptr 1.
        cycle(4'b1111, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 40; j++)
            cycle(4'b1111, 4'b0000, 1'b1, 1'b0, j == 39, 1'b0, j == 39);
        cycle(4'b1111, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(40, 1'b0);

        // Reset with 5 in flight: none may respond, counters must be clear.
        cycle(4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_rst();
        drain(40, 1'b1);
        for (int c = 0; c < 5; c++)
            cycle(4'b0100, (c < 4) ? 4'b0100 : 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
